cache_ctrl: RTL and testbench

//  Two-port controller that sequences the small fully-associative cache and the backing memory.

---
 rtl/cache_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: two-port sequencer for a small fully-associative cache and its
// backing memory. Port 0 is instruction fetch, port 1 is data/tape access.
// A round-robin arbiter grants one request at a time. Read misses fill the
// cache. Writes go through to memory and then allocate a cache entry. Only
// one transaction is in flight.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   pN_req/we/addr/wdata requester N (N=0,1); req held until pN_ack
//   pN_rdata, pN_ack    read data (held until next ack to N), 1-cycle ack
//   cache_req/we/addr/wdata, cache_rdata, cache_hit   cache lookup/fill
//   mem_req/we/addr/wdata, mem_rdata, mem_ready       backing memory
//   busy                high whenever the controller is not idle
//
// Optional build macro CACHE_STATS_EN adds saturating hit_cnt/miss_cnt
// outputs (STAT_WIDTH bits) counting lookup hits and misses.

module cache_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
`ifdef CACHE_STATS_EN
    ,
    parameter int STAT_WIDTH = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_ack,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_ack,
    output logic                  cache_req,
    output logic                  cache_we,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    input  logic                  cache_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] hit_cnt,
    output logic [STAT_WIDTH-1:0] miss_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_RD,
        S_MEM_WR,
        S_FILL,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   p0_rdata_q, p0_rdata_d;
    logic [DATA_WIDTH-1:0]   p1_rdata_q, p1_rdata_d;

    logic any_req;
    logic sel;      // port chosen this cycle if in IDLE
    logic sel_we;

    // Round-robin: with both requesting, the port not granted last time wins.
    always_comb begin
        any_req = p0_req | p1_req;
        sel     = (p0_req & p1_req) ? ~last_grant_q : p1_req;
        sel_we  = sel ? p1_we : p0_we;
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (any_req) state_d = sel_we ? S_MEM_WR : S_LOOKUP;
            S_LOOKUP: state_d = cache_hit ? S_RESP : S_MEM_RD;
            S_MEM_RD: if (mem_ready) state_d = S_FILL;
            S_MEM_WR: if (mem_ready) state_d = S_FILL;
            S_FILL:   state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    // The per-port read registers load on the edge that enters RESP so the
    // value is already on pN_rdata during the ack cycle and then holds.
    always_comb begin
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d        = sel;
                    last_grant_d = sel;
                    addr_d       = sel ? p1_addr  : p0_addr;
                    wdata_d      = sel ? p1_wdata : p0_wdata;
                end
            end
            S_LOOKUP: begin
                if (cache_hit) begin
                    data_d = cache_rdata;
                    if (gnt_q) p1_rdata_d = cache_rdata;
                    else       p0_rdata_d = cache_rdata;
                end
            end
            S_MEM_RD: if (mem_ready) data_d = mem_rdata;
            S_MEM_WR: if (mem_ready) data_d = wdata_q;
            S_FILL: begin
                if (gnt_q) p1_rdata_d = data_q;
                else       p0_rdata_d = data_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_q       <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        cache_req   = 1'b0;
        cache_we    = 1'b0;
        cache_addr  = '0;
        cache_wdata = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        p0_ack      = 1'b0;
        p1_ack      = 1'b0;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_LOOKUP: begin
                cache_req  = 1'b1;
                cache_addr = addr_q;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            S_FILL: begin
                cache_we    = 1'b1;
                cache_addr  = addr_q;
                cache_wdata = data_q;
            end
            S_RESP: begin
                p0_ack = ~gnt_q;
                p1_ack = gnt_q;
            end
            default: ;
        endcase
    end

    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

    // ---------------- optional lookup statistics ----------------
`ifdef CACHE_STATS_EN
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

    logic [STAT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [STAT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    // Counted on the LOOKUP cycle only, so writes never touch the counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == S_LOOKUP) begin
            if (cache_hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + STAT_ONE;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + STAT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    // Statistics disabled: no counter hardware.
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CN = 8;   // entries in the bench's cache model

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          p0_ack, p1_ack;
    logic          cache_req, cache_we, cache_hit;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata, cache_rdata;
    logic          mem_req, mem_we;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    cache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .cache_req(cache_req), .cache_we(cache_we), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
    logic [1:0]  s2_hit, s2_miss;
    logic [DW-1:0] d2_p0_rdata, d2_p1_rdata, d2_cache_wdata, d2_mem_wdata;
    logic [AW-1:0] d2_cache_addr, d2_mem_addr;
    logic d2_p0_ack, d2_p1_ack, d2_cache_req, d2_cache_we, d2_mem_req, d2_mem_we, d2_busy;

    // Narrow-counter copy sharing every input, to observe saturation.
    cache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STAT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(d2_p0_rdata), .p0_ack(d2_p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(d2_p1_rdata), .p1_ack(d2_p1_ack),
        .cache_req(d2_cache_req), .cache_we(d2_cache_we), .cache_addr(d2_cache_addr),
        .cache_wdata(d2_cache_wdata), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
        .mem_req(d2_mem_req), .mem_we(d2_mem_we), .mem_addr(d2_mem_addr),
        .mem_wdata(d2_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(d2_busy), .hit_cnt(s2_hit), .miss_cnt(s2_miss)
    );
`endif

    int checks = 0;
    int errors = 0;

    // ---------------- environment: cache and memory models ----------------
    int            force_mode = 0;   // 0 model, 1 always hit, 2 always miss
    logic [DW-1:0] force_data = '0;
    logic [AW-1:0] c_addr [CN];
    logic [DW-1:0] c_data [CN];
    logic          c_val  [CN] = '{default: 1'b0};

    // Lookup returns the youngest matching entry (index 0 is youngest).
    always_comb begin
        cache_hit   = 1'b0;
        cache_rdata = '0;
        if (cache_req) begin
            if (force_mode == 1) begin
                cache_hit   = 1'b1;
                cache_rdata = force_data;
            end else if (force_mode == 0) begin
                for (int i = CN - 1; i >= 0; i--) begin
                    if (c_val[i] && c_addr[i] == cache_addr) begin
                        cache_hit   = 1'b1;
                        cache_rdata = c_data[i];
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (cache_we) begin
            for (int i = CN - 1; i > 0; i--) begin
                c_addr[i] <= c_addr[i-1];
                c_data[i] <= c_data[i-1];
                c_val[i]  <= c_val[i-1];
            end
            c_addr[0] <= cache_addr;
            c_data[0] <= cache_wdata;
            c_val[0]  <= 1'b1;
        end
    end

    function automatic bit predict_hit(input logic [AW-1:0] a);
        if (force_mode == 1) return 1'b1;
        if (force_mode == 2) return 1'b0;
        for (int i = 0; i < CN; i++) if (c_val[i] && c_addr[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    logic [DW-1:0] bmem    [256];   // backing memory contents
    logic [DW-1:0] ref_mem [256];   // reference: value a read must return
    int mem_wait = 1;               // mem_ready asserted in the mem_wait-th request cycle
    int wcnt = 0;

    always @(negedge clk) begin
        if (mem_ready || !mem_req) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end else begin
            wcnt++;
            if (wcnt >= mem_wait) begin
                mem_ready = 1'b1;
                mem_rdata = bmem[mem_addr];
                if (mem_we) bmem[mem_addr] = mem_wdata;
            end
        end
    end

    // ---------------- transaction driver ----------------
    int            exp_hits = 0, exp_miss = 0;
    bit            m_last = 1'b1;   // model of the last-granted port
    int            ack_order[$];
    int            t_lat, t_nmem, t_nfill;
    bit            t_overlap, t_mwe;
    logic [AW-1:0] t_maddr, t_faddr;
    logic [DW-1:0] t_mwd, t_fdata;

    task automatic txn(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, output logic [DW-1:0] rd, output bit tmo);
        int cyc;
        if (!we) begin
            if (predict_hit(a)) exp_hits++;
            else exp_miss++;
        end
        if (p == 0) begin
            p0_we = we; p0_addr = a; p0_wdata = wd; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = a; p1_wdata = wd; p1_req = 1'b1;
        end
        t_lat = 0; t_nmem = 0; t_nfill = 0; t_overlap = 0;
        tmo = 1'b0; rd = '0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy) t_lat++;
            if (cache_req && cache_we) t_overlap = 1'b1;
            if (mem_req) begin
                t_nmem++; t_mwe = mem_we; t_maddr = mem_addr; t_mwd = mem_wdata;
            end
            if (cache_we) begin
                t_nfill++; t_faddr = cache_addr; t_fdata = cache_wdata;
            end
            if ((p == 0 && p0_ack) || (p == 1 && p1_ack)) begin
                rd = (p == 0) ? p0_rdata : p1_rdata;
                ack_order.push_back(p);
                break;
            end
            if (cyc >= 200) begin
                tmo = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (p == 0) p0_req = 1'b0;
        else p1_req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, mem_req, cache_req, cache_we, p0_ack, p1_ack} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {busy, mem_req, cache_req, cache_we, p0_ack, p1_ack});
        end
        checks++;
        if ({p0_rdata, p1_rdata, mem_addr, cache_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data: got p0=%h p1=%h ma=%h ca=%h expected all 0", p0_rdata, p1_rdata, mem_addr, cache_addr);
        end
        rst = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic test_read_hit();
        logic [DW-1:0] rd; bit tmo;
        force_mode = 1; force_data = 8'hA5;
        txn(0, 1'b0, 8'h10, 8'h00, rd, tmo);
        m_last = 1'b0;
        force_mode = 0;
        checks++;
        if (tmo || rd !== 8'hA5) begin
            errors++; $display("FAIL hit_data: got %h tmo=%0d expected a5", rd, tmo);
        end
        checks++;
        if (t_lat !== 2) begin
            errors++; $display("FAIL hit_latency: got %0d expected 2", t_lat);
        end
        checks++;
        if (t_nmem !== 0 || t_nfill !== 0) begin
            errors++; $display("FAIL hit_no_mem: got mem=%0d fill=%0d expected 0 0", t_nmem, t_nfill);
        end
    endtask

    task automatic test_read_miss();
        logic [DW-1:0] rd; bit tmo;
        bmem[8'h20] = 8'h3C; ref_mem[8'h20] = 8'h3C;
        mem_wait = 3;
        txn(1, 1'b0, 8'h20, 8'h00, rd, tmo);
        m_last = 1'b1;
        checks++;
        if (tmo || rd !== 8'h3C) begin
            errors++; $display("FAIL miss_data: got %h tmo=%0d expected 3c", rd, tmo);
        end
        checks++;
        if (t_lat !== 6 || t_nmem !== 3) begin
            errors++; $display("FAIL miss_latency: got lat=%0d mem=%0d expected 6 3", t_lat, t_nmem);
        end
        checks++;
        if (t_nfill !== 1 || t_faddr !== 8'h20 || t_fdata !== 8'h3C) begin
            errors++; $display("FAIL miss_fill: got n=%0d a=%h d=%h expected 1 20 3c", t_nfill, t_faddr, t_fdata);
        end
        checks++;
        if (p0_rdata !== 8'hA5) begin
            errors++; $display("FAIL rdata_hold: got %h expected a5", p0_rdata);
        end
    endtask

    task automatic pair(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input string nm);
        logic [DW-1:0] rd0, rd1; bit tmo0, tmo1; int first;
        first = m_last ? 0 : 1;   // both requesting: the port not granted last wins
        ack_order.delete();
        fork
            txn(0, 1'b0, a0, 8'h00, rd0, tmo0);
            txn(1, 1'b0, a1, 8'h00, rd1, tmo1);
        join
        checks++;
        if (tmo0 || tmo1 || ack_order.size() != 2 || ack_order[0] != first || ack_order[1] != 1 - first) begin
            errors++;
            $display("FAIL %s_order: got first=%0d n=%0d tmo=%0d%0d expected first=%0d", nm,
                     (ack_order.size() > 0) ? ack_order[0] : -1, ack_order.size(), tmo0, tmo1, first);
        end
        checks++;
        if (rd0 !== ref_mem[a0] || rd1 !== ref_mem[a1]) begin
            errors++;
            $display("FAIL %s_data: got %h %h expected %h %h", nm, rd0, rd1, ref_mem[a0], ref_mem[a1]);
        end
    endtask

    task automatic test_arbitration();
        logic [DW-1:0] rd; bit tmo;
        mem_wait = 2;
        pair(8'h80, 8'h81, "arb_first");
        txn(0, 1'b0, 8'h82, 8'h00, rd, tmo);
        m_last = 1'b0;
        checks++;
        if (tmo || rd !== ref_mem[8'h82]) begin
            errors++; $display("FAIL arb_single: got %h expected %h", rd, ref_mem[8'h82]);
        end
        pair(8'h83, 8'h84, "arb_alternate");
    endtask

    task automatic test_write_alloc();
        logic [DW-1:0] rd; bit tmo;
        mem_wait = 2;
        txn(1, 1'b1, 8'h30, 8'h55, rd, tmo);
        m_last = 1'b1;
        ref_mem[8'h30] = 8'h55;
        checks++;
        if (tmo || t_nmem !== 2 || t_mwe !== 1'b1 || t_maddr !== 8'h30 || t_mwd !== 8'h55) begin
            errors++;
            $display("FAIL wr_mem: got n=%0d we=%0d a=%h d=%h expected 2 1 30 55", t_nmem, t_mwe, t_maddr, t_mwd);
        end
        checks++;
        if (t_nfill !== 1 || t_faddr !== 8'h30 || t_fdata !== 8'h55 || t_lat !== 4) begin
            errors++;
            $display("FAIL wr_fill: got n=%0d a=%h d=%h lat=%0d expected 1 30 55 4", t_nfill, t_faddr, t_fdata, t_lat);
        end
        txn(0, 1'b0, 8'h30, 8'h00, rd, tmo);
        m_last = 1'b0;
        checks++;
        if (tmo || rd !== 8'h55 || t_lat !== 2 || t_nmem !== 0) begin
            errors++;
            $display("FAIL wr_then_hit: got d=%h lat=%0d mem=%0d expected 55 2 0", rd, t_lat, t_nmem);
        end
    endtask

    task automatic test_reset_abort();
        bit seen; logic [DW-1:0] rd0, rd1; bit tmo0, tmo1;
        force_mode = 2; mem_wait = 20;
        p0_we = 1'b0; p0_addr = 8'h50; p0_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_req;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL abort_reach_mem: got mem_req=0 expected 1");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, mem_req, p0_ack, p1_ack} !== 4'b0) begin
            errors++; $display("FAIL abort_state: got %b expected 0000", {busy, mem_req, p0_ack, p1_ack});
        end
        rst = 1'b0;
        m_last = 1'b1; exp_hits = 0; exp_miss = 0; mem_wait = 2;
        ack_order.delete();
        fork
            txn(0, 1'b0, 8'h50, 8'h00, rd0, tmo0);
            txn(1, 1'b0, 8'h51, 8'h00, rd1, tmo1);
        join
        force_mode = 0;
        checks++;
        if (tmo0 || tmo1 || ack_order.size() != 2 || ack_order[0] != 0) begin
            errors++;
            $display("FAIL abort_grant: got first=%0d tmo=%0d%0d expected first=0",
                     (ack_order.size() > 0) ? ack_order[0] : -1, tmo0, tmo1);
        end
        checks++;
        if (rd0 !== ref_mem[8'h50] || rd1 !== ref_mem[8'h51]) begin
            errors++;
            $display("FAIL abort_data: got %h %h expected %h %h", rd0, rd1, ref_mem[8'h50], ref_mem[8'h51]);
        end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        logic [DW-1:0] rd; bit tmo;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        m_last = 1'b1; exp_hits = 0; exp_miss = 0; mem_wait = 1;
        force_mode = 1;
        for (int i = 0; i < 3; i++) begin txn(i % 2, 1'b0, 8'h90, 8'h00, rd, tmo); m_last = (i % 2) != 0; end
        force_mode = 2;
        for (int i = 0; i < 2; i++) begin txn(0, 1'b0, 8'h91, 8'h00, rd, tmo); m_last = 1'b0; end
        txn(1, 1'b1, 8'h92, 8'hEE, rd, tmo);   // writes are not counted
        m_last = 1'b1; ref_mem[8'h92] = 8'hEE;
        checks++;
        if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2 || s2_hit !== 2'd3 || s2_miss !== 2'd2) begin
            errors++;
            $display("FAIL stats_count: got %0d %0d %0d %0d expected 3 2 3 2", hit_cnt, miss_cnt, s2_hit, s2_miss);
        end
        force_mode = 1;
        for (int i = 0; i < 2; i++) begin txn(0, 1'b0, 8'h93, 8'h00, rd, tmo); m_last = 1'b0; end
        force_mode = 0;
        checks++;
        if (hit_cnt !== 16'd5 || s2_hit !== 2'd3) begin
            errors++; $display("FAIL stats_saturate: got %0d %0d expected 5 3", hit_cnt, s2_hit);
        end
    endtask
`endif

    task automatic test_random();
        logic [DW-1:0] rd, wd, exp_rd; logic [AW-1:0] a;
        bit tmo, we, hit; int p, w, exp_lat, exp_nmem, exp_nfill, bad;
        bad = 0;
        force_mode = 0;
        for (int i = 0; i < 60; i++) begin
            p  = $urandom_range(0, 1);
            we = ($urandom_range(0, 2) == 0);
            a  = 8'h40 + AW'($urandom_range(0, 11));
            wd = DW'($urandom);
            w  = $urandom_range(1, 4);
            mem_wait = w;
            hit = predict_hit(a);
            exp_rd    = we ? wd : ref_mem[a];
            exp_lat   = we ? 2 + w : (hit ? 2 : 3 + w);
            exp_nmem  = (we || !hit) ? w : 0;
            exp_nfill = (we || !hit) ? 1 : 0;
            txn(p, we, a, wd, rd, tmo);
            m_last = (p != 0);
            if (we) ref_mem[a] = wd;
            checks++;
            if (tmo || rd !== exp_rd) begin
                errors++; bad++;
                $display("FAIL rand_data[%0d]: p=%0d we=%0d a=%h got %h expected %h", i, p, we, a, rd, exp_rd);
            end
            checks++;
            if (t_lat !== exp_lat || t_nmem !== exp_nmem || t_nfill !== exp_nfill || t_overlap) begin
                errors++; bad++;
                $display("FAIL rand_timing[%0d]: got lat=%0d mem=%0d fill=%0d ovl=%0d expected %0d %0d %0d 0",
                         i, t_lat, t_nmem, t_nfill, t_overlap, exp_lat, exp_nmem, exp_nfill);
            end
            if (bad > 10) break;
        end
`ifdef CACHE_STATS_EN
        checks++;
        if (hit_cnt !== 16'(exp_hits) || miss_cnt !== 16'(exp_miss)) begin
            errors++;
            $display("FAIL rand_stats: got %0d %0d expected %0d %0d", hit_cnt, miss_cnt, exp_hits, exp_miss);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            bmem[i]    = DW'($urandom);
            ref_mem[i] = bmem[i];
        end
        test_reset();
        test_read_hit();
        test_read_miss();
        test_arbitration();
        test_write_alloc();
        test_reset_abort();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
